// File: rtl/stall_mem_pkg.sv
// +--------------------------------------------------------------------+
// | stall_mem_pkg : shared state encoding and default sizing constants |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package stall_mem_pkg;

   localparam int LATENCY_DEF    = 4;
   localparam int DEPTH_LOG2_DEF = 8;
   // Wide enough for the largest preload value, LATENCY_MAX - 2 = 5.
   localparam int CNT_W          = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/stall_mem_array.sv
// +--------------------------------------------------------------------+
// | stall_mem_array : 2^DEPTH_LOG2 x 16 storage, sync write, async read |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module stall_mem_array
   import stall_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [15:0]           wdata,
   output logic [15:0]           rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // No reset: contents survive a reset of the controller.
   logic [15:0] mem_q [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = mem_q[idx];

endmodule

`default_nettype wire

// File: rtl/stall_mem_resp.sv
// +--------------------------------------------------------------------+
// | stall_mem_resp : fixed-latency stalling memory with done/err pulses |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module stall_mem_resp
   import stall_mem_pkg::*;
#(
   parameter int LATENCY    = LATENCY_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        done,
   output logic        err
);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [15:0]             wdata_q, wdata_d;
   logic                    wr_q, wr_d;
   logic [15:0]             dout_q, dout_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic                    w_req;
   logic                    w_accept;
   logic                    w_reject;
   logic                    w_mem_we;
   logic                    w_stall;
   logic [15:0]             w_mem_rdata;
   logic [15:0]             w_unused_addr;

   // Upper address bits alias onto the array; only the word index matters.
   assign w_unused_addr = addr;

   assign w_req    = rd ^ wr;
   assign w_accept = rst && (state_q == ST_IDLE) && w_req && !addr[0];
   assign w_reject = rst && (state_q == ST_IDLE) && ((rd && wr) || (w_req && addr[0]));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      dout_d   = 16'h0000;
      done_d   = 1'b0;
      err_d    = 1'b0;
      w_mem_we = 1'b0;
      w_stall  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_W'(LATENCY - 2);
               idx_d   = addr[DEPTH_LOG2:1];
               wdata_d = data_in;
               wr_d    = wr;
               w_stall = 1'b1;
            end else if (w_reject) begin
               err_d = 1'b1;
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            if (cnt_q == '0) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               w_mem_we = wr_q && rst;
               dout_d   = wr_q ? 16'h0000 : w_mem_rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            // Requests seen here are dropped; the requester must retry in IDLE.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         wr_q    <= 1'b0;
         dout_q  <= 16'h0000;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   stall_mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .we    (w_mem_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (w_mem_rdata)
   );

   assign data_out = dout_q;
   assign stall    = w_stall;
   assign done     = done_q;
   assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_stall_mem_resp.sv
// +--------------------------------------------------------------------+
// | tb_stall_mem_resp : scoreboard bench, LATENCY=4 and LATENCY=2 DUTs  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_stall_mem_resp;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rd_a, wr_a, stall_a, done_a, err_a;
   logic [15:0] addr_a, din_a, dout_a;
   logic        rst_b, rd_b, wr_b, stall_b, done_b, err_b;
   logic [15:0] addr_b, din_b, dout_b;

   stall_mem_resp #(.LATENCY(4), .DEPTH_LOG2(8)) u_dut_a (
      .clk(clk), .rst(rst_a), .addr(addr_a), .data_in(din_a), .rd(rd_a), .wr(wr_a),
      .data_out(dout_a), .stall(stall_a), .done(done_a), .err(err_a)
   );

   stall_mem_resp #(.LATENCY(2), .DEPTH_LOG2(8)) u_dut_b (
      .clk(clk), .rst(rst_b), .addr(addr_b), .data_in(din_b), .rd(rd_b), .wr(wr_b),
      .data_out(dout_b), .stall(stall_b), .done(done_b), .err(err_b)
   );

   typedef struct {
      bit          is_err;
      logic [15:0] data;
      int          at;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, expv);
      end
   endtask

   task automatic mon(input int sel, input logic dn, input logic er, input logic [15:0] dout);
      exp_t e;
      if (dn || er) begin
         if ((sel == 0 ? q_a.size() : q_b.size()) == 0) begin
            chk(sel == 0 ? "unexpected_resp_a" : "unexpected_resp_b", {14'b0, er, dn}, 16'h0000);
         end else begin
            if (sel == 0) e = q_a.pop_front();
            else          e = q_b.pop_front();
            chk("resp_kind",  {14'b0, er, dn}, e.is_err ? 16'h0002 : 16'h0001);
            chk("resp_cycle", 16'(cyc), 16'(e.at));
            chk("resp_data",  dout, e.data);
         end
      end else begin
         chk(sel == 0 ? "idle_data_out_a" : "idle_data_out_b", dout, 16'h0000);
      end
   endtask

   always @(negedge clk) begin
      mon(0, done_a, err_a, dout_a);
      mon(1, done_b, err_b, dout_b);
   end

   function automatic logic get_stall(input int sel);
      return (sel == 0) ? stall_a : stall_b;
   endfunction

   task automatic set_in(input int sel, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
      if (sel == 0) begin rd_a = r; wr_a = w; addr_a = a; din_a = d; end
      else          begin rd_b = r; wr_b = w; addr_b = a; din_b = d; end
   endtask

   task automatic push(input int sel, input bit is_err, input logic [15:0] d, input int at);
      exp_t e;
      e.is_err = is_err; e.data = d; e.at = at;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
   endtask

   // Legal request; chg swaps rd/wr and data during the first BUSY cycle.
   task automatic legal_req(input int sel, input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] expd, input bit chg);
      int lat;
      lat = (sel == 0) ? 4 : 2;
      set_in(sel, r, w, a, d);
      push(sel, 1'b0, expd, cyc + lat);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         chk("stall_busy", {15'b0, get_stall(sel)}, 16'h0001);
         @(posedge clk); #1;
         if (chg && k == 0) set_in(sel, ~r, ~w, a, 16'h0BAD);
      end
      set_in(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("stall_done", {15'b0, get_stall(sel)}, 16'h0000);
      @(posedge clk); #1;
   endtask

   task automatic bad_req(input int sel, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
      set_in(sel, r, w, a, d);
      push(sel, 1'b1, 16'h0000, cyc + 1);
      @(negedge clk);
      chk("stall_reject", {15'b0, get_stall(sel)}, 16'h0000);
      @(posedge clk); #1;
      set_in(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("stall_after_reject", {15'b0, get_stall(sel)}, 16'h0000);
      @(posedge clk); #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: cycle %0d got timeout expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      set_in(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_in(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      // A request held while in reset must not be taken.
      set_in(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      chk("stall_in_reset", {15'b0, stall_a}, 16'h0000);
      @(posedge clk); #1;
      set_in(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      rst_a = 1'b1; rst_b = 1'b1;
      @(negedge clk);
      chk("reset_stall_a", {15'b0, stall_a}, 16'h0000);
      chk("reset_stall_b", {15'b0, stall_b}, 16'h0000);
      @(posedge clk); #1;

      // LATENCY=4 instance
      legal_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
      legal_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      legal_req(0, 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0);
      bad_req  (0, 1'b1, 1'b1, 16'h0020, 16'hFFFF);
      legal_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0);
      bad_req  (0, 1'b1, 1'b0, 16'h0011, 16'h0000);
      bad_req  (0, 1'b0, 1'b1, 16'h0011, 16'h2222);
      legal_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      legal_req(0, 1'b1, 1'b0, 16'h0210, 16'h0000, 16'hBEEF, 1'b0);

      legal_req(0, 1'b0, 1'b1, 16'h0030, 16'h5678, 16'h0000, 1'b0);
      // Write of 0x1234 aborted by reset in cycle 2.
      set_in(0, 1'b0, 1'b1, 16'h0030, 16'h1234);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_stall", {15'b0, stall_a}, 16'h0000);
      chk("abort_done",  {15'b0, done_a},  16'h0000);
      chk("abort_err",   {15'b0, err_a},   16'h0000);
      chk("abort_dout",  dout_a,           16'h0000);
      @(posedge clk); #1;
      set_in(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      rst_a = 1'b1;
      @(posedge clk); #1;
      legal_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5678, 1'b0);

      legal_req(0, 1'b0, 1'b1, 16'h0050, 16'hCAFE, 16'h0000, 1'b0);
      legal_req(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 16'hCAFE, 1'b0);

      // LATENCY=2 instance, back-to-back with inputs changed during BUSY
      legal_req(1, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 16'h0000, 1'b1);
      legal_req(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5A5, 1'b1);
      legal_req(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5A5, 1'b0);
      bad_req  (1, 1'b1, 1'b1, 16'h0040, 16'h0000);

      repeat (4) @(posedge clk);
      #1;
      chk("queue_a_drained", 16'(q_a.size()), 16'h0000);
      chk("queue_b_drained", 16'(q_b.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stall_mem_resp.md
STALL_MEM_RESP -- requirements
Module: stall_mem_resp

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request cycle to done cycle; legal range 2..7.
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of storage depth in 16-bit words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, synchronous, active-low (rst=0 resets on the clk edge).
REQ-005 addr  input  16  byte address; word index = addr[DEPTH_LOG2:1].
REQ-006 data_in  input  16  write data.
REQ-007 rd  input  1  read request.
REQ-008 wr  input  1  write request.
REQ-009 data_out  output  16  read data; valid only while done=1, else 16'h0000.
REQ-010 stall  output  1  request in progress; requester holds addr/data_in/rd/wr.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle illegal-request pulse.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 A request is rd XOR wr sampled in IDLE; addr, data_in, wr SHALL be latched at that edge and the FSM SHALL move to BUSY.
REQ-015 The request cycle is cycle 0; done SHALL be 1 in cycle LATENCY exactly, 0 otherwise.
REQ-016 stall SHALL be 1 in cycle 0 (combinational from IDLE and legal request) and in every BUSY cycle (1..LATENCY-1); 0 in IDLE without request and in DONE.
REQ-017 BUSY SHALL use a down-counter loaded with LATENCY-2 on acceptance, moving to DONE when it reaches 0 (LATENCY=2 gives one BUSY cycle).
REQ-018 Writes SHALL commit to storage on the BUSY->DONE edge using latched addr/data; data_out SHALL be registered on the same edge from latched addr.
REQ-019 DONE SHALL return to IDLE unconditionally after one cycle; rd/wr presented in DONE SHALL be ignored.
REQ-020 rd/wr changes during BUSY SHALL be ignored; latched values govern the access.
REQ-021 rd=1 and wr=1 together in IDLE SHALL not be accepted: no access, FSM stays IDLE, stall=0, err=1 in the next cycle.
REQ-022 A legal request with addr[0]=1 SHALL likewise be rejected with err=1 next cycle, no access.
REQ-023 Address bits above DEPTH_LOG2 SHALL be ignored (aliasing wrap-around).
REQ-024 A read of a word written by the immediately preceding request SHALL return the new data.

Reset
REQ-025 rst=0 SHALL force IDLE, counter 0, latched request cleared, data_out=0, done=0, err=0, stall=0 after the edge.
REQ-026 rst=0 during BUSY SHALL abort the request; a pending write SHALL NOT commit.
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 While rst=0, requests SHALL be ignored.

Structure
REQ-029 A shared package stall_mem_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default LATENCY and DEPTH_LOG2 constants.
REQ-030 Storage SHALL be one sub-module, stall_mem_array: 2^DEPTH_LOG2 x 16, synchronous write, asynchronous read.
REQ-031 FSM, counter, request latch and output registers SHALL reside in stall_mem_resp.

Verification
REQ-032 Write addr=16'h0010, data_in=16'hBEEF, LATENCY=4 -> stall=1 cycles 0..3, done=1 cycle 4 only, data_out=0.
REQ-033 Read addr=16'h0010 next -> done cycle 4, data_out=16'hBEEF in that cycle only, 0 before/after.
REQ-034 rd=1,wr=1 addr=16'h0020 -> stall=0, err=1 cycle 1 only, later read of 16'h0020 returns prior contents.
REQ-035 Read addr=16'h0011 -> err=1 cycle 1, no done, FSM IDLE.
REQ-036 Write 16'h1234 to 16'h0030, rst=0 in cycle 2 -> outputs 0 after edge, later read of 16'h0030 returns old value, not 16'h1234.
REQ-037 LATENCY=2, back-to-back write 16'hA5A5 then read same addr (0x0040), req changed during BUSY -> done cycles 2 and 5, data_out=16'hA5A5 cycle 5.
